// File: rtl/uart_rx.sv
// uart_rx -- 8N1 serial receiver, LSB first, idle-high line.
//
// Deserialises the incoming line into bytes. Each byte is held in a
// single-entry holding register until the consumer acknowledges it.
// Bad stop bits and dropped bytes are reported through sticky flags.
//
// Ports
//   PCLK       in   system clock, rising edge
//   PRESET     in   synchronous active-high reset
//   rx         in   asynchronous serial line (idles high)
//   rd_ack     in   one-cycle pulse: consumer has taken data_out
//   err_clr    in   one-cycle pulse: clears frame_err and overrun
//   data_out   out  [7:0] holding-register byte
//   data_valid out  holding register contains an unread byte
//   frame_err  out  sticky: a frame ended with a low stop bit
//   overrun    out  sticky: a byte was dropped, holding register full
//   busy       out  receiver FSM is not idle
//
// Parameters
//   CLKS_PER_BIT  PCLK cycles per bit period (>= 4)
//   SYNC_STAGES   flops in the rx synchroniser (2 or 3)

module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       rx,
    input  logic       rd_ack,
    input  logic       err_clr,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          baud_q;
    logic [2:0]             bit_idx_q;
    logic                   busy_q;
    logic [7:0]             shift_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs_prev_q;

    logic [7:0] data_q,  data_d;
    logic       valid_q, valid_d;
    logic       ferr_q,  ferr_d;
    logic       ovr_q,   ovr_d;

    logic rxs;
    logic stop_sample;
    logic commit;
    logic bad_stop;

    // Synchroniser flops reset to 1 so that reset never looks like a
    // start edge on a line that is idling high.
    assign rxs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sync_q     <= '1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rx};
            rxs_prev_q <= rxs;
        end
    end

    // Receive FSM. busy_q is updated together with every state change so
    // that it always equals (state_q != S_IDLE) without extra decode.
    // A start needs a high-to-low transition of rxs: after a break the
    // line must be seen high again before another frame can begin.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!rxs && rxs_prev_q) begin
                        state_q <= S_START;
                        baud_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (baud_q == HALF_LAST) begin
                        baud_q <= '0;
                        if (rxs) begin
                            // High at mid start bit: a glitch, not a frame.
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= S_DATA;
                            bit_idx_q <= '0;
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            // Index stays at 7 through STOP.
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= '0;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    baud_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Data bits land directly in their final position, LSB first.
    always_ff @(posedge PCLK) begin
        if (state_q == S_DATA && baud_q == BAUD_LAST) begin
            shift_q[bit_idx_q] <= rxs;
        end
    end

    assign stop_sample = (state_q == S_STOP) && (baud_q == BAUD_LAST);
    assign commit      = stop_sample && rxs;
    assign bad_stop    = stop_sample && !rxs;

    // Holding register and sticky flags. Ordering matters: the clear and
    // acknowledge are applied first so a same-cycle set or commit wins.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;

        if (err_clr) begin
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end

        if (rd_ack) begin
            valid_d = 1'b0;
        end

        if (commit) begin
            if (!valid_q || rd_ack) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end

        if (bad_stop) begin
            ferr_d = 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = busy_q;

endmodule
